// File: rtl/sysarr_result_collector_pkg.sv
// Shared helpers for the systolic-array result collector: row slicing, FIFO sizing, ReLU.
// Default geometry lives here so the top and the bench agree on widths.
package sysarr_result_collector_pkg;

  localparam int PSUM_BW        = 19;
  localparam int PE_ROWS        = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_PTR_W = ptr_width(FIFO_DEPTH_DEF);

  // LSB of row `row` inside a packed row bus of `bw`-bit rows.
  function automatic int row_lsb(input int row, input int bw);
    return row * bw;
  endfunction

  function automatic logic [PSUM_BW-1:0] relu(input logic [PSUM_BW-1:0] v);
    return v[PSUM_BW-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/sysarr_vec_fifo.sv
// Generic first-word-fallthrough vector FIFO with occupancy count and drop strobe.
// Head is read straight from register storage; a push when full is accepted only with a same-cycle pop.
module sysarr_vec_fifo
  import sysarr_result_collector_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic                     out_vld_o,
  output logic [WIDTH-1:0]         out_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    do_pop  = pop_i && !empty && !clear_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    do_push = push_i && !clear_i && (!full || do_pop);
    drop_o  = push_i && !clear_i && full && !do_pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign out_vld_o = !empty;
  assign out_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/sysarr_result_collector.sv
// Deskews the row-skewed partial-sum bus into aligned vectors and queues them for a valid/ready consumer.
// out_valid rises NUM_PE_ROWS cycles after row 0; full FIFO without a pop drops the vector (sticky overflow). SYSARR_COLLECT_RELU_EN clamps negative rows to 0.
module sysarr_result_collector
  import sysarr_result_collector_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = PSUM_BW,
  parameter int NUM_PE_ROWS    = PE_ROWS,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  in_valid,
  input  logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0] in_result,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0] out_data,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic                                  overflow
);

  localparam int N     = NUM_PE_ROWS;
  localparam int W     = PARTIAL_SUM_BW;
  localparam int VEC_W = N * W;

  logic [N-2:0]     vld_q, vld_d;
  logic             aligned_vld;
  logic [VEC_W-1:0] aligned_vec;
  logic [VEC_W-1:0] push_vec;
  logic             drop_vld;
  logic             overflow_q, overflow_d;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int k = 1; k < N - 1; k++) vld_d[k] = vld_q[k-1];
    if (clear) vld_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign aligned_vld = vld_q[N-2];

  // Row r arrives r cycles late, so it waits N-1-r cycles to line up with row N-1.
  for (genvar r = 0; r < N; r++) begin : g_row
    if (r == N - 1) begin : g_direct
      assign aligned_vec[row_lsb(r, W) +: W] = in_result[row_lsb(r, W) +: W];
    end else begin : g_dly
      localparam int DLY = N - 1 - r;
      logic [W-1:0] sr_q [DLY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) sr_q[i] <= '0;
        end else begin
          sr_q[0] <= in_result[row_lsb(r, W) +: W];
          for (int i = 1; i < DLY; i++) sr_q[i] <= sr_q[i-1];
        end
      end

      assign aligned_vec[row_lsb(r, W) +: W] = sr_q[DLY-1];
    end
  end

`ifdef SYSARR_COLLECT_RELU_EN
  always_comb begin
    push_vec = '0;
    for (int r = 0; r < N; r++) begin
      push_vec[row_lsb(r, W) +: W] = relu(aligned_vec[row_lsb(r, W) +: W]);
    end
  end
`else
  assign push_vec = aligned_vec;
`endif

  sysarr_vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .push_i     (aligned_vld),
    .push_dat_i (push_vec),
    .pop_i      (out_ready),
    .out_vld_o  (out_valid),
    .out_dat_o  (out_data),
    .count_o    (fifo_count),
    .drop_o     (drop_vld)
  );

  // Only reset clears the overflow flag; clear leaves it for software to inspect.
  assign overflow_d = overflow_q | drop_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

endmodule

// File: doc/sysarr_result_collector.md
Name: sysarr_result_collector

Overview:
- Output side of the systolic array: consumes the per-row partial-sum bus and row-0 valid strobe produced by the array.
- Each array result vector leaves the array skewed: row i is valid one cycle after row i-1.
- Deskews rows into one aligned vector, optionally applies ReLU, and buffers vectors in a FIFO drained by a valid/ready consumer (writeback/output SRAM controller).

Parameters:
- PARTIAL_SUM_BW, 19, width of one row's signed partial sum
- NUM_PE_ROWS, 8, number of PE rows (N); sets deskew depth
- FIFO_DEPTH, 4, aligned-vector FIFO entries; power of two, >=2

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush of deskew pipe and FIFO; overflow flag unaffected
- in_valid  in  1  row 0 of a new result vector present on in_result this cycle
- in_result  in  N*PARTIAL_SUM_BW  signed row results, row i at bits [(i+1)*PARTIAL_SUM_BW-1 -: PARTIAL_SUM_BW]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid&&out_ready
- out_data  out  N*PARTIAL_SUM_BW  aligned vector, same row packing as in_result
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: an aligned vector was dropped because FIFO was full

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, fifo_count=0, overflow=0; deskew registers and valid pipe zeroed. Reset mid-operation discards all in-flight vectors; no partial vector emitted after release.
- Skew contract: when in_valid=1 in cycle t, row i of that vector is sampled from in_result in cycle t+i. in_valid may assert every cycle (back-to-back vectors fully pipelined).
- Deskew: row i passes through N-1-i registers; row N-1 is taken directly. A valid shift pipe of depth N-1 tracks in_valid. In cycle t+N-1 all rows of the vector are aligned and pushed at the end of that cycle.
- Latency: with FIFO empty and out_ready ignored, out_valid rises in cycle t+N (8 cycles at default). out_data is registered from FIFO storage (no combinational path from in_result).
- FIFO: first-word-fallthrough, registered head. Pop when out_valid&&out_ready. Push when an aligned vector exists.
- Full + push + pop in same cycle: both happen; count unchanged; no overflow.
- Full + push, no pop: vector dropped; overflow set and held until rst (clear does not reset it).
- Empty + pop: impossible (out_valid=0); no state change.
- Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
- out_data held stable while out_valid=1 and out_ready=0.
- clear=1: valid pipe and FIFO emptied at the next edge; out_valid=0 the following cycle. A push coincident with clear is discarded. Inputs sampled during clear are ignored for skew tracking.
- No arithmetic besides optional ReLU; widths preserved, no truncation.

Optional Feature:
- Macro SYSARR_COLLECT_RELU_EN.
- Defined: each row value is replaced by 0 when negative (sign bit set), applied to the aligned vector before FIFO push; no added latency.
- Undefined: values pass unmodified.

Decomposition:
- Shared package: row-slice index helper function, FIFO pointer width constant derived from FIFO_DEPTH, ReLU function on PARTIAL_SUM_BW signed values.
- One sub-module: sysarr_vec_fifo (parameterised width/depth FWFT FIFO with count), reusable for the input-side feeder.

Test Plan:
- Single vector: rows 0..7 = 1,-2,3,-4,5,-6,7,-8, each presented at t+i, out_ready=1 -> out_valid at t+8 for exactly 1 cycle, out_data rows = 1,-2,...,-8.
- Back-to-back: 6 vectors on consecutive cycles (row i of vector k = 10*k+i) -> 6 consecutive out_valid cycles starting t+8, in order, rows intact.
- Backpressure: out_ready=0, push 5 vectors with FIFO_DEPTH=4 -> fifo_count=4, overflow=1 after 5th aligns, first 4 vectors drained in order after out_ready=1.
- Full simultaneous push/pop: FIFO full, out_ready=1 same cycle as push -> count stays 4, overflow stays 0.
- rst pulse mid-vector (cycle t+3) -> outputs zero immediately; no out_valid for that vector after release.
- clear after 2 vectors buffered -> fifo_count=0, out_valid=0 next cycle, overflow unchanged; with SYSARR_COLLECT_RELU_EN, row -5 -> 0, row 5 -> 5.
